// File: rtl/apb_reg_decoder.sv
// APB slave with a five-register bank (CTRL, DATA0, DATA1, STATUS, ID),
// programmable wait states and error flagging on unmapped or read-only writes.
module apb_reg_decoder #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic [7:0] ctrl_o,
  output logic [7:0] data0_o,
  output logic [7:0] data1_o,
  output logic       err_o,
  output logic [1:0] state_o
);

  // Handshake: a transfer starts on a setup edge (psel=1, penable=0) and
  // completes on the first edge where psel=1, penable=1 and pready=1.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic       write_q, write_d;
  logic       acc_err_q, acc_err_d;
  logic       pslverr_q, pslverr_d;
  logic [7:0] ctrl_q, ctrl_d;
  logic [7:0] data0_q, data0_d;
  logic [7:0] data1_q, data1_d;
  logic       st_err_q, st_err_d;
  logic [3:0] err_cnt_q, err_cnt_d;

  logic setup;
  logic setup_err;
  logic load;
  logic complete;

  assign setup     = psel && !penable;
  assign setup_err = (paddr > 8'h04) || (pwrite && (paddr == 8'h03 || paddr == 8'h04));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    acc_err_d = acc_err_q;
    pslverr_d = pslverr_q;
    ctrl_d    = ctrl_q;
    data0_d   = data0_q;
    data1_d   = data1_q;
    st_err_d  = st_err_q;
    err_cnt_d = err_cnt_q;
    load      = 1'b0;
    complete  = 1'b0;

    case (state_q)
      IDLE: begin
        if (setup) load = 1'b1;
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q == 3'd0) begin
            state_d  = DONE;
            complete = 1'b1;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      DONE: begin
        if (!psel) begin
          state_d   = IDLE;
          pslverr_d = 1'b0;
        end else if (setup) begin
          load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d   = ACCESS;
      addr_d    = paddr;
      write_d   = pwrite;
      cnt_d     = WAIT_LOAD;
      acc_err_d = setup_err;
    end
    if (setup) pslverr_d = 1'b0;

    // Commit and STATUS update happen only once, on the completion edge.
    if (complete) begin
      pslverr_d = acc_err_q;
      st_err_d  = acc_err_q;
      if (acc_err_q && err_cnt_q != 4'hF) err_cnt_d = err_cnt_q + 4'd1;
      if (write_q && !acc_err_q) begin
        case (addr_q)
          8'h00:   ctrl_d  = pwdata;
          8'h01:   data0_d = pwdata;
          8'h02:   data1_d = pwdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= 8'h00;
      write_q   <= 1'b0;
      acc_err_q <= 1'b0;
      pslverr_q <= 1'b0;
      ctrl_q    <= 8'h00;
      data0_q   <= 8'h00;
      data1_q   <= 8'h00;
      st_err_q  <= 1'b0;
      err_cnt_q <= 4'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      acc_err_q <= acc_err_d;
      pslverr_q <= pslverr_d;
      ctrl_q    <= ctrl_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      st_err_q  <= st_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Read data decodes the live address so it is valid already in setup.
  always_comb begin
    prdata = 8'h00;
    if (psel && !pwrite) begin
      case (paddr)
        8'h00:   prdata = ctrl_q;
        8'h01:   prdata = data0_q;
        8'h02:   prdata = data1_q;
        8'h03:   prdata = {err_cnt_q, 3'b000, st_err_q};
        8'h04:   prdata = ID_VALUE;
        default: prdata = 8'h00;
      endcase
    end
  end

  assign pready  = (state_q == ACCESS && cnt_q == 3'd0) || (state_q == DONE);
  assign pslverr = pslverr_q;
  assign ctrl_o  = ctrl_q;
  assign data0_o = data0_q;
  assign data1_o = data1_q;
  assign err_o   = st_err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_apb_reg_decoder.sv
// Directed bench for apb_reg_decoder: one instance with no wait states and
// one with three, sharing the same APB master signals.
module tb_apb_reg_decoder;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;

  logic [7:0] prdata0, ctrl0, data0_0, data1_0;
  logic       pready0, pslverr0, err0;
  logic [1:0] state0;

  logic [7:0] prdata3, ctrl3, data0_3, data1_3;
  logic       pready3, pslverr3, err3;
  logic [1:0] state3;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2;

  always #5 pclk = ~pclk;

  apb_reg_decoder #(.WAIT_CYCLES(0), .ID_VALUE(8'hA5)) u_dut0 (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata0),
    .pready(pready0), .pslverr(pslverr0), .ctrl_o(ctrl0), .data0_o(data0_0),
    .data1_o(data1_0), .err_o(err0), .state_o(state0)
  );

  apb_reg_decoder #(.WAIT_CYCLES(3), .ID_VALUE(8'hA5)) u_dut3 (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata3),
    .pready(pready3), .pslverr(pslverr3), .ctrl_o(ctrl3), .data0_o(data0_3),
    .data1_o(data1_3), .err_o(err3), .state_o(state3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic apb_setup(input logic [7:0] a, input logic w, input logic [7:0] d);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    #1;
  endtask

  task automatic apb_idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    apb_idle();
    tick();
    tick();
    presetn = 1'b1;
    tick();
  endtask

  initial begin
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00;
    #2;
    do_reset();

    check("rst_state",   state0, S_IDLE);
    check("rst_pready",  pready0, 1'b0);
    check("rst_pslverr", pslverr0, 1'b0);
    check("rst_ctrl",    ctrl0, 8'h00);
    check("rst_err_o",   err0, 1'b0);
    apb_setup(8'h03, 1'b0, 8'h00);
    check("rst_status",  prdata0, 8'h00);
    apb_idle();

    // Zero-wait write of 0x5A to DATA0
    apb_setup(8'h01, 1'b1, 8'h5A);
    tick();
    check("w0_pready",   pready0, 1'b1);
    check("w0_pre_data", data0_0, 8'h00);
    penable = 1'b1;
    tick();
    check("w0_data0",    data0_0, 8'h5A);
    check("w0_pslverr",  pslverr0, 1'b0);
    check("w0_state",    state0, S_DONE);
    apb_idle();
    tick();
    check("w0_idle_rdy", pready0, 1'b0);

    // Readback of DATA0 in setup and access
    apb_setup(8'h01, 1'b0, 8'h00);
    check("r0_setup",    prdata0, 8'h5A);
    tick();
    penable = 1'b1;
    #1;
    check("r0_access",   prdata0, 8'h5A);
    tick();
    check("r0_pslverr",  pslverr0, 1'b0);
    apb_idle();
    check("r0_nosel",    prdata0, 8'h00);
    tick();

    // Write to read-only ID register
    apb_setup(8'h04, 1'b1, 8'h33);
    tick();
    penable = 1'b1;
    tick();
    check("wid_pslverr", pslverr0, 1'b1);
    tick();
    check("wid_hold_err", pslverr0, 1'b1);
    check("wid_hold_rdy", pready0, 1'b1);
    apb_idle();
    tick();
    check("wid_clr_err", pslverr0, 1'b0);
    check("wid_err_o",   err0, 1'b1);
    apb_setup(8'h03, 1'b0, 8'h00);
    check("wid_status",  prdata0, 8'h11);
    paddr = 8'h04;
    #1;
    check("wid_id",      prdata0, 8'hA5);
    apb_idle();

    // Good write clears STATUS[0] but keeps the count
    apb_setup(8'h00, 1'b1, 8'h77);
    tick();
    penable = 1'b1;
    tick();
    apb_idle();
    tick();
    check("good_ctrl",   ctrl0, 8'h77);
    check("good_err_o",  err0, 1'b0);
    apb_setup(8'h03, 1'b0, 8'h00);
    check("good_status", prdata0, 8'h10);
    apb_idle();

    // Unmapped read, master holds the access for 3 extra cycles
    apb_setup(8'h80, 1'b0, 8'h00);
    check("unm_prdata",  prdata0, 8'h00);
    tick();
    penable = 1'b1;
    tick();
    check("unm_pslverr", pslverr0, 1'b1);
    for (int k = 0; k < 3; k++) tick();
    check("unm_hold_err", pslverr0, 1'b1);
    check("unm_hold_st", state0, S_DONE);
    apb_idle();
    tick();
    apb_setup(8'h03, 1'b0, 8'h00);
    check("unm_status",  prdata0, 8'h21);
    apb_idle();

    // 17 back-to-back erroneous writes, setup straight from DONE
    for (int i = 0; i < 17; i++) begin
      apb_setup(8'h10, 1'b1, 8'(i));
      tick();
      if (i == 5) begin
        check("b2b_state",   state0, S_ACCESS);
        check("b2b_pslverr", pslverr0, 1'b0);
      end
      penable = 1'b1;
      tick();
      if (i == 5) check("b2b_done", state0, S_DONE);
    end
    apb_idle();
    tick();
    check("sat_err_o",   err0, 1'b1);
    apb_setup(8'h03, 1'b0, 8'h00);
    check("sat_status",  prdata0, 8'hF1);
    apb_idle();

    // Three wait states: write 0xC3 to DATA1
    do_reset();
    apb_setup(8'h02, 1'b1, 8'hC3);
    tick();
    penable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("w3_pready_lo", pready3, 1'b0);
      check("w3_data1_old", data1_3, 8'h00);
      tick();
    end
    check("w3_pready_hi", pready3, 1'b1);
    check("w3_data1_pre", data1_3, 8'h00);
    tick();
    check("w3_data1",    data1_3, 8'hC3);
    check("w3_pslverr",  pslverr3, 1'b0);
    apb_idle();
    tick();
    apb_setup(8'h02, 1'b0, 8'h00);
    check("w3_readback", prdata3, 8'hC3);
    apb_idle();

    // Reset during a wait state of a write to CTRL
    apb_setup(8'h00, 1'b1, 8'h99);
    tick();
    penable = 1'b1;
    tick();
    check("rw_waiting",  pready3, 1'b0);
    presetn = 1'b0;
    tick();
    check("rw_state",    state3, S_IDLE);
    check("rw_ctrl",     ctrl3, 8'h00);
    check("rw_pready",   pready3, 1'b0);
    check("rw_pslverr",  pslverr3, 1'b0);
    presetn = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("rw_no_commit", ctrl3, 8'h00);
    check("rw_still_idle", state3, S_IDLE);
    apb_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
